// File: rtl/legv8_alu_exec_if.sv
// Bus bundle for the LEGv8 execute stage: operand/opcode inputs and the
// registered result/flag outputs. The master side drives operands, the
// slave side (the execute stage) drives results.
interface legv8_alu_exec_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  iValid;
    logic [1:0]            iALUOp;
    logic [10:0]           iOpcode;
    logic [5:0]            iShamt;
    logic [DATA_WIDTH-1:0] iOperandA;
    logic [DATA_WIDTH-1:0] iOperandB;

    logic                  oValid;
    logic [3:0]            oALUControl;
    logic [DATA_WIDTH-1:0] oResult;
    logic                  oZero;
    logic                  oNeg;
    logic                  oCarry;
    logic                  oOverflow;
    logic                  oIllegal;

    modport master (
        output iValid, iALUOp, iOpcode, iShamt, iOperandA, iOperandB,
        input  oValid, oALUControl, oResult, oZero, oNeg, oCarry, oOverflow, oIllegal
    );

    modport slave (
        input  iValid, iALUOp, iOpcode, iShamt, iOperandA, iOperandB,
        output oValid, oALUControl, oResult, oZero, oNeg, oCarry, oOverflow, oIllegal
    );
endinterface

// File: rtl/legv8_alu_exec.sv
// LEGv8 execute stage: ALU-control decode (ALUOp + opcode) feeding a
// DATA_WIDTH-bit ALU, with result, control code and flags registered
// (one cycle latency). Optional LSL/LSR support is enabled by defining
// the macro ALU_SHIFT_EN; without it those opcodes decode as illegal.
module legv8_alu_exec #(
    parameter int DATA_WIDTH = 64
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    legv8_alu_exec_if.slave    bus
);
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_ORR  = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_PASS = 4'b0111;
    localparam logic [3:0] CTL_LSL  = 4'b1000;
    localparam logic [3:0] CTL_LSR  = 4'b1001;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_ILL  = 4'b1111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
`ifdef ALU_SHIFT_EN
    localparam logic [10:0] OPC_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_LSR = 11'b11010011010;
`endif

    logic [3:0]                   ctl;
    logic                         illegal;
    logic        [DATA_WIDTH-1:0] b_eff;
    logic        [DATA_WIDTH:0]   sum_ext;
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic signed [DATA_WIDTH-1:0] sum_s;
    logic                         add_ovf;
    logic        [DATA_WIDTH-1:0] res_nxt;
    logic                         carry_nxt;
    logic                         ovf_nxt;

    logic                         vld_p1;
    logic [3:0]                   ctl_p1;
    logic        [DATA_WIDTH-1:0] res_p1;
    logic                         zero_p1;
    logic                         neg_p1;
    logic                         carry_p1;
    logic                         ovf_p1;
    logic                         ill_p1;

`ifndef ALU_SHIFT_EN
    // Shift amount has no consumer when shifts are compiled out.
    logic unused_shamt;
    assign unused_shamt = ^bus.iShamt;
`endif

    // ALU-control decode: ALUOp selects fixed ops, R-type looks at the opcode.
    always_comb begin
        ctl     = CTL_ILL;
        illegal = 1'b1;
        case (bus.iALUOp)
            2'b00: begin ctl = CTL_ADD;  illegal = 1'b0; end
            2'b01: begin ctl = CTL_PASS; illegal = 1'b0; end
            2'b10: begin
                case (bus.iOpcode)
                    OPC_ADD: begin ctl = CTL_ADD; illegal = 1'b0; end
                    OPC_SUB: begin ctl = CTL_SUB; illegal = 1'b0; end
                    OPC_AND: begin ctl = CTL_AND; illegal = 1'b0; end
                    OPC_ORR: begin ctl = CTL_ORR; illegal = 1'b0; end
`ifdef ALU_SHIFT_EN
                    OPC_LSL: begin ctl = CTL_LSL; illegal = 1'b0; end
                    OPC_LSR: begin ctl = CTL_LSR; illegal = 1'b0; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Shared adder: subtraction is A + ~B + 1, so carry-out is NOT borrow.
    always_comb begin
        b_eff   = (ctl == CTL_SUB) ? ~bus.iOperandB : bus.iOperandB;
        sum_ext = {1'b0, bus.iOperandA} + {1'b0, b_eff}
                + {{DATA_WIDTH{1'b0}}, (ctl == CTL_SUB)};
        a_s     = $signed(bus.iOperandA);
        b_s     = $signed(b_eff);
        sum_s   = $signed(sum_ext[DATA_WIDTH-1:0]);
        add_ovf = ((a_s < 0) == (b_s < 0)) && ((sum_s < 0) != (a_s < 0));
    end

    // Result mux; carry/overflow only meaningful for add/sub, zero otherwise.
    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (ctl)
            CTL_AND:  res_nxt = bus.iOperandA & bus.iOperandB;
            CTL_ORR:  res_nxt = bus.iOperandA | bus.iOperandB;
            CTL_ADD, CTL_SUB: begin
                res_nxt   = sum_ext[DATA_WIDTH-1:0];
                carry_nxt = sum_ext[DATA_WIDTH];
                ovf_nxt   = add_ovf;
            end
            CTL_PASS: res_nxt = bus.iOperandB;
            CTL_NOR:  res_nxt = ~(bus.iOperandA | bus.iOperandB);
`ifdef ALU_SHIFT_EN
            CTL_LSL:  res_nxt = bus.iOperandA << bus.iShamt;
            CTL_LSR:  res_nxt = bus.iOperandA >> bus.iShamt;
`endif
            default:  res_nxt = '0;
        endcase
    end

    // Output register: valid follows every edge, payload loads only when valid.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vld_p1   <= 1'b0;
            ctl_p1   <= '0;
            res_p1   <= '0;
            zero_p1  <= 1'b0;
            neg_p1   <= 1'b0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
            ill_p1   <= 1'b0;
        end else begin
            vld_p1 <= bus.iValid;
            if (bus.iValid) begin
                ctl_p1   <= ctl;
                res_p1   <= res_nxt;
                zero_p1  <= (res_nxt == '0);
                neg_p1   <= res_nxt[DATA_WIDTH-1];
                carry_p1 <= carry_nxt;
                ovf_p1   <= ovf_nxt;
                ill_p1   <= illegal;
            end
        end
    end

    // ---- stage p1: registered outputs ----
    assign bus.oValid      = vld_p1;
    assign bus.oALUControl = ctl_p1;
    assign bus.oResult     = res_p1;
    assign bus.oZero       = zero_p1;
    assign bus.oNeg        = neg_p1;
    assign bus.oCarry      = carry_p1;
    assign bus.oOverflow   = ovf_p1;
    assign bus.oIllegal    = ill_p1;
endmodule

// File: tb/tb_legv8_alu_exec.sv
// Self-checking bench for legv8_alu_exec: directed vectors followed by
// randomized operations, compared against an arithmetic reference model.
module tb_legv8_alu_exec;
    localparam int W = 64;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_LSR = 11'b11010011010;

    typedef struct packed {
        logic       vld;
        logic [3:0] ctl;
        logic [W-1:0] res;
        logic z, n, c, v, ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t expst;

    logic         d_vld;
    logic [1:0]   d_op;
    logic [10:0]  d_opc;
    logic [5:0]   d_sh;
    logic [W-1:0] d_a;
    logic [W-1:0] d_b;

    legv8_alu_exec_if #(.DATA_WIDTH(W)) bus ();

    legv8_alu_exec #(.DATA_WIDTH(W)) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: what one valid operation should produce, from the ISA rules.
    function automatic exp_t model(input logic [1:0] op, input logic [10:0] opc,
                                   input logic [5:0] sh, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa, sb, sr;
        e = '0;
        e.vld = 1'b1;
        e.ill = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'b00 || (op == 2'b10 && opc == OPC_ADD)) begin
            e.ctl = 4'b0010;
            e.res = a + b;
            e.c = (e.res < a);
            sr = $signed(e.res);
            e.v = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
        end else if (op == 2'b01) begin
            e.ctl = 4'b0111;
            e.res = b;
        end else if (op == 2'b10 && opc == OPC_SUB) begin
            e.ctl = 4'b0110;
            e.res = a - b;
            e.c = (a >= b);
            sr = $signed(e.res);
            e.v = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
        end else if (op == 2'b10 && opc == OPC_AND) begin
            e.ctl = 4'b0000;
            e.res = a & b;
        end else if (op == 2'b10 && opc == OPC_ORR) begin
            e.ctl = 4'b0001;
            e.res = a | b;
`ifdef ALU_SHIFT_EN
        end else if (op == 2'b10 && opc == OPC_LSL) begin
            e.ctl = 4'b1000;
            e.res = a * (64'd1 << sh);
        end else if (op == 2'b10 && opc == OPC_LSR) begin
            e.ctl = 4'b1001;
            e.res = a / (64'd1 << sh);
`endif
        end else begin
            e.ctl = 4'b1111;
            e.res = '0;
            e.ill = 1'b1;
        end
        e.z = (e.res == 0);
        e.n = e.ill ? 1'b0 : e.res[W-1];
        if (sh == 6'h3f && e.ctl == 4'b1111) e.n = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, W'(bus.oValid),      W'(expst.vld));
        chk({tag, ".ctl"},   W'(bus.oALUControl), W'(expst.ctl));
        chk({tag, ".res"},   bus.oResult,         expst.res);
        chk({tag, ".z"},     W'(bus.oZero),       W'(expst.z));
        chk({tag, ".n"},     W'(bus.oNeg),        W'(expst.n));
        chk({tag, ".c"},     W'(bus.oCarry),      W'(expst.c));
        chk({tag, ".v"},     W'(bus.oOverflow),   W'(expst.v));
        chk({tag, ".ill"},   W'(bus.oIllegal),    W'(expst.ill));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc,
                         input logic [5:0] sh, input logic [W-1:0] a, input logic [W-1:0] b);
        d_vld = v; d_op = op; d_opc = opc; d_sh = sh; d_a = a; d_b = b;
        bus.iValid = v; bus.iALUOp = op; bus.iOpcode = opc;
        bus.iShamt = sh; bus.iOperandA = a; bus.iOperandB = b;
    endtask

    // One clock: model what the edge should have captured, then compare.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (d_vld) begin
                e = model(d_op, d_opc, d_sh, d_a, d_b);
                expst = e;
            end
            expst.vld = d_vld;
        end
        check_all(tag);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'(1);
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [10:0] opcs [6];
        opcs[0] = OPC_ADD; opcs[1] = OPC_SUB; opcs[2] = OPC_AND;
        opcs[3] = OPC_ORR; opcs[4] = OPC_LSL; opcs[5] = OPC_LSR;
        expst = '0;
        drive(1'b0, 2'b00, 11'd0, 6'd0, '0, '0);

        #3;
        check_all("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        drive(1'b1, 2'b10, OPC_ADD, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("add_ovf");
        chk("add_ovf.const_res", bus.oResult, 64'h8000_0000_0000_0000);
        chk("add_ovf.const_v", W'(bus.oOverflow), W'(1));

        drive(1'b1, 2'b10, OPC_SUB, 6'd0, 64'd5, 64'd5);
        step("sub_eq");
        chk("sub_eq.const_z", W'(bus.oZero), W'(1));
        chk("sub_eq.const_c", W'(bus.oCarry), W'(1));

        drive(1'b1, 2'b10, OPC_SUB, 6'd0, 64'd0, 64'd1);
        step("sub_neg");
        chk("sub_neg.const_res", bus.oResult, '1);

        drive(1'b1, 2'b01, 11'd0, 6'd0, 64'h1234, 64'd0);
        step("pass_b");
        drive(1'b1, 2'b00, 11'd0, 6'd0, 64'h100, 64'h8);
        step("ldst_add");
        chk("ldst_add.const_res", bus.oResult, 64'h108);
        drive(1'b1, 2'b10, OPC_AND, 6'd0, 64'hF0F0, 64'h0FF0);
        step("and");
        chk("and.const_res", bus.oResult, 64'h00F0);
        drive(1'b1, 2'b10, OPC_ORR, 6'd0, 64'hF0F0, 64'h0FF0);
        step("orr");
        chk("orr.const_res", bus.oResult, 64'hFFF0);
        drive(1'b1, 2'b11, OPC_ADD, 6'd0, 64'd3, 64'd4);
        step("aluop11");
        chk("aluop11.const_ill", W'(bus.oIllegal), W'(1));
        drive(1'b1, 2'b10, OPC_LSL, 6'd63, 64'd1, 64'd0);
        step("lsl63");
`ifdef ALU_SHIFT_EN
        chk("lsl63.const_res", bus.oResult, 64'h8000_0000_0000_0000);
`else
        chk("lsl63.const_ill", W'(bus.oIllegal), W'(1));
`endif
        drive(1'b1, 2'b10, OPC_LSR, 6'd4, 64'hF000_0000_0000_0000, 64'd0);
        step("lsr4");

        drive(1'b1, 2'b10, OPC_ADD, 6'd0, 64'd10, 64'd20);
        step("pre_hold");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), opcs[$urandom_range(0, 5)],
                  6'($urandom_range(0, 63)), rand_operand(), rand_operand());
            step("hold");
        end

        // Asynchronous reset between edges, inputs still valid.
        drive(1'b1, 2'b10, OPC_SUB, 6'd0, 64'd0, 64'd1);
        step("pre_rst");
        rst_n = 1'b0;
        #1;
        expst = '0;
        check_all("rst_async");
        step("rst_held");
        step("rst_held2");
        drive(1'b0, 2'b00, 11'd0, 6'd0, '0, '0);
        rst_n = 1'b1;
        step("rst_release");
        drive(1'b1, 2'b00, 11'd0, 6'd0, 64'd7, 64'd9);
        step("first_after_rst");

        for (int i = 0; i < 300; i++) begin
            logic [10:0] opc;
            opc = ($urandom_range(0, 7) == 0) ? 11'($urandom()) : opcs[$urandom_range(0, 5)];
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), opc,
                  6'($urandom_range(0, 63)), rand_operand(), rand_operand());
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
